lb_task_scheduler: RTL and testbench
====================================

Name: lb_task_scheduler

Overview:
- Sequencing controller in front of the three-server load-balancing datapath.
- Accepts an 8-bit task mask through a valid/ready handshake and dispatches one task per cycle to the least-loaded server, with rotating tie-break.
- Tracks per-server outstanding counts; servers retire tasks via per-server done strobes.
- Flags batch completion (trigger) and capacity exhaustion (overload).

Parameters:
- TASK_W, 8: width of the task mask; one bit per task.
- CNT_W, 4: width of each server count.
- CAP, 15: maximum outstanding tasks per server (CAP <= 2^CNT_W - 1).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- batch_valid  in  1  a task batch is offered
- batch_ready  out  1  scheduler is idle and can accept a batch
- batch_tasks  in  TASK_W  task mask; bit i set means task i is present
- done  in  3  done[k]: server k+1 retired one task this cycle
- dispatch_valid  out  1  a task is issued this cycle
- dispatch_server  out  2  target server: 0, 1 or 2 (server1..server3)
- dispatch_idx  out  3  index of the issued task bit
- server1_count  out  CNT_W  outstanding tasks, server1
- server2_count  out  CNT_W  outstanding tasks, server2
- server3_count  out  CNT_W  outstanding tasks, server3
- trigger  out  1  one-cycle pulse when a batch is fully dispatched
- overload  out  1  tasks pending and every server at CAP

Behaviour:
- Reset values (at the reset edge): state=IDLE, pending mask=0, rr_ptr=0, all counts=0, trigger=0.
- Outputs during and after reset: dispatch_valid=0, overload=0; batch_ready is held 0 while reset=1.
- States:
  - IDLE: batch_ready=1. On batch_valid, latch batch_tasks into pending. Mask nonzero -> SCAN; mask zero -> DONE.
  - SCAN: all outputs combinational from registered state.
    - Select idx = lowest set bit of pending.
    - Eligible servers are those with count < CAP. Select the minimum count among them; ties resolve in rotating priority starting at rr_ptr.
    - If any server is eligible: dispatch_valid=1. At the edge, clear pending[idx], increment the chosen count, set rr_ptr=(sel+1) mod 3.
    - If the remaining pending mask is zero after this dispatch -> DONE.
    - If no server is eligible: dispatch_valid=0, overload=1, stay in SCAN (stall).
  - DONE: trigger=1 for exactly one cycle -> IDLE.
- Latency (N tasks, no stall):
  - Accept edge E0.
  - dispatch_valid high in cycles 1..N.
  - trigger high in cycle N+1.
  - batch_ready high in cycle N+2.
- Count update per server k, each edge:
  - +1 if dispatched to k; -1 if done[k] and count>0.
  - Both in the same cycle: unchanged.
  - done[k] with count=0 is ignored (no wrap).
- Selection uses the registered counts. A same-cycle done does not make a full server eligible until the next cycle.
- done is honoured in every state, including IDLE and DONE.
- batch_valid outside IDLE is ignored; batch_tasks is sampled only on acceptance.
- Counts are never incremented beyond CAP.
- Reset mid-batch: pending is discarded, no trigger, counts cleared, rr_ptr=0.

Decomposition:
- Shared package lb_pkg holds:
  - NUM_SERVERS=3
  - state enum {IDLE, SCAN, DONE}
  - server-id typedef (2 bits)
  - count typedef
- Sub-module lb_min_select: combinational picker.
  - Inputs: three counts, CAP, rr_ptr.
  - Outputs: sel, any_eligible.

Test Plan:
- Six-task dispatch: reset 2 cycles, then batch 8'b01011111, no done.
  - Required dispatches: (idx0,s0), (1,s1), (2,s2), (3,s0), (4,s1), (6,s2).
  - Final counts 2/2/2; trigger in cycle 7; batch_ready high in cycle 8.
- Empty batch: batch 8'h00 -> no dispatch_valid; trigger in cycle 1; batch_ready high in cycle 2.
- Overload and stall with CAP=2: batch 8'hFF.
  - First 6 tasks dispatch, then overload=1 and dispatch stalls.
  - Pulse done[1] -> next cycle idx6 goes to s1 and overload drops, then rises again.
  - Pulse done[0] -> idx7 goes to s0; trigger follows.
- Simultaneous events: done[0] in the same cycle as a dispatch to s0 -> server1_count unchanged. done[2] with server3_count=0 -> stays 0.
- Reset mid-batch: batch 8'hFF, assert reset after 3 dispatches.
  - Next cycle: counts 0, no trigger, batch_ready=1 once reset deasserts.
  - New batch 8'h01 -> dispatched to s0.
- Back-pressure: batch_valid held during SCAN with a different mask -> ignored; the original batch completes unchanged.

Source files
------------

// File: rtl/lb_pkg.sv
// Shared types for the load-balancing task scheduler: server count, FSM
// states, server id and count types.
package lb_pkg;
  localparam int NUM_SERVERS = 3;
  localparam int COUNT_W     = 4;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  typedef logic [1:0]         server_id_t;
  typedef logic [COUNT_W-1:0] count_t;
endpackage

// File: rtl/lb_min_select.sv
// Combinational least-loaded picker over three servers; servers at cap are
// skipped and ties go to the first candidate in rotation order from rr_ptr.
module lb_min_select
  import lb_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic [CNT_W-1:0] count0,
  input  logic [CNT_W-1:0] count1,
  input  logic [CNT_W-1:0] count2,
  input  logic [CNT_W-1:0] cap,
  input  server_id_t       rr_ptr,
  output server_id_t       sel,
  output logic             any_eligible
);

  logic [CNT_W-1:0] best;
  logic [CNT_W-1:0] cur;
  logic [2:0]       pos;
  server_id_t       k;

  always_comb begin
    sel          = '0;
    any_eligible = 1'b0;
    best         = '0;
    cur          = '0;
    pos          = '0;
    k            = '0;
    // Strict less-than keeps the earliest candidate in rotation on a tie.
    for (int i = 0; i < NUM_SERVERS; i++) begin
      pos = {1'b0, rr_ptr} + 3'(i);
      if (pos >= 3'd3) pos = pos - 3'd3;
      k   = pos[1:0];
      cur = (k == 2'd0) ? count0 : (k == 2'd1) ? count1 : count2;
      if (cur < cap && (!any_eligible || cur < best)) begin
        any_eligible = 1'b1;
        best         = cur;
        sel          = k;
      end
    end
  end

endmodule

// File: rtl/lb_task_scheduler.sv
// Accepts a task mask and issues one task per cycle to the least-loaded
// server, tracking outstanding work per server and flagging batch end/overload.
module lb_task_scheduler
  import lb_pkg::*;
#(
  parameter int TASK_W = 8,
  parameter int CNT_W  = 4,
  parameter int CAP    = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      batch_valid,
  output logic                      batch_ready,
  input  logic [TASK_W-1:0]         batch_tasks,
  input  logic [NUM_SERVERS-1:0]    done,
  output logic                      dispatch_valid,
  output server_id_t                dispatch_server,
  output logic [$clog2(TASK_W)-1:0] dispatch_idx,
  output logic [CNT_W-1:0]          server1_count,
  output logic [CNT_W-1:0]          server2_count,
  output logic [CNT_W-1:0]          server3_count,
  output logic                      trigger,
  output logic                      overload
);

  localparam int IDX_W = $clog2(TASK_W);

  state_t                 state, state_nx;
  logic [TASK_W-1:0]      pending, pending_nx, idx_mask;
  server_id_t             rr_ptr, rr_nx, sel;
  logic                   any_eligible;
  logic [CNT_W-1:0]       cnt [NUM_SERVERS];
  logic [NUM_SERVERS-1:0] inc, dec;

  assign server1_count   = cnt[0];
  assign server2_count   = cnt[1];
  assign server3_count   = cnt[2];
  assign dispatch_server = sel;

  // Descending scan so the lowest set bit is the last one written.
  always_comb begin
    dispatch_idx = '0;
    idx_mask     = '0;
    for (int i = TASK_W - 1; i >= 0; i--) begin
      if (pending[i]) begin
        dispatch_idx = IDX_W'(i);
        idx_mask     = TASK_W'(1) << i;
      end
    end
  end

  lb_min_select #(.CNT_W(CNT_W)) u_min_select (
    .count0       (cnt[0]),
    .count1       (cnt[1]),
    .count2       (cnt[2]),
    .cap          (CNT_W'(CAP)),
    .rr_ptr       (rr_ptr),
    .sel          (sel),
    .any_eligible (any_eligible)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
      rr_ptr  <= rr_nx;
    end
  end

  // Outputs are masked while reset is high since the state may still be stale.
  always_comb begin
    state_nx       = state;
    pending_nx     = pending;
    rr_nx          = rr_ptr;
    batch_ready    = 1'b0;
    dispatch_valid = 1'b0;
    overload       = 1'b0;
    trigger        = 1'b0;
    case (state)
      IDLE: begin
        batch_ready = !reset;
        if (batch_valid) begin
          pending_nx = batch_tasks;
          state_nx   = (|batch_tasks) ? SCAN : DONE;
        end
      end
      SCAN: begin
        if (any_eligible) begin
          dispatch_valid = !reset;
          pending_nx     = pending & ~idx_mask;
          rr_nx          = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
          if (pending_nx == '0) state_nx = DONE;
        end else begin
          overload = !reset;
        end
      end
      DONE: begin
        trigger  = !reset;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    inc = '0;
    dec = '0;
    for (int k = 0; k < NUM_SERVERS; k++) begin
      inc[k] = dispatch_valid && (sel == server_id_t'(k));
      dec[k] = done[k] && (cnt[k] != '0);
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_SERVERS; k++) begin
      if (reset)                 cnt[k] <= '0;
      else if (inc[k] && !dec[k]) cnt[k] <= cnt[k] + 1'b1;
      else if (dec[k] && !inc[k]) cnt[k] <= cnt[k] - 1'b1;
    end
  end

endmodule

// File: tb/tb_lb_task_scheduler.sv
// Directed bench for lb_task_scheduler: expected dispatches are queued when a
// batch is offered and popped as the scheduler issues them.
module tb_lb_task_scheduler;

  localparam int TASK_W = 8;
  localparam int CNT_W  = 4;
  localparam int CAP    = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              batch_valid;
  logic              batch_ready;
  logic [TASK_W-1:0] batch_tasks;
  logic [2:0]        done;
  logic              dispatch_valid;
  logic [1:0]        dispatch_server;
  logic [2:0]        dispatch_idx;
  logic [CNT_W-1:0]  server1_count, server2_count, server3_count;
  logic              trigger;
  logic              overload;

  typedef struct packed {
    logic [2:0] idx;
    logic [1:0] srv;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // Small cap so that stall and overload are reachable with an 8-task mask.
  lb_task_scheduler #(.TASK_W(TASK_W), .CNT_W(CNT_W), .CAP(CAP)) dut (
    .clk             (clk),
    .reset           (reset),
    .batch_valid     (batch_valid),
    .batch_ready     (batch_ready),
    .batch_tasks     (batch_tasks),
    .done            (done),
    .dispatch_valid  (dispatch_valid),
    .dispatch_server (dispatch_server),
    .dispatch_idx    (dispatch_idx),
    .server1_count   (server1_count),
    .server2_count   (server2_count),
    .server3_count   (server3_count),
    .trigger         (trigger),
    .overload        (overload)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] idx, input logic [1:0] srv);
    exp_t e;
    e.idx = idx;
    e.srv = srv;
    sbq.push_back(e);
  endtask

  // Advance to the next falling edge and score any dispatch seen there.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (dispatch_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("spurious_dispatch", 32'(dispatch_valid), 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("disp_idx", 32'(dispatch_idx), 32'(e.idx));
        chk("disp_srv", 32'(dispatch_server), 32'(e.srv));
      end
    end
  endtask

  task automatic chk_counts(input string tag, input int c1, input int c2, input int c3);
    chk({tag, "_s1"}, 32'(server1_count), 32'(c1));
    chk({tag, "_s2"}, 32'(server2_count), 32'(c2));
    chk({tag, "_s3"}, 32'(server3_count), 32'(c3));
  endtask

  initial begin
    reset       = 1'b1;
    batch_valid = 1'b0;
    batch_tasks = '0;
    done        = '0;

    // Reset
    cyc();
    chk("rst_ready", 32'(batch_ready), 32'd0);
    chk("rst_dv", 32'(dispatch_valid), 32'd0);
    chk("rst_ovl", 32'(overload), 32'd0);
    chk("rst_trig", 32'(trigger), 32'd0);
    cyc();
    chk("rst_ready2", 32'(batch_ready), 32'd0);
    reset = 1'b0;
    cyc();
    chk("post_rst_ready", 32'(batch_ready), 32'd1);
    chk_counts("post_rst", 0, 0, 0);

    // Six tasks, balanced round robin
    batch_valid = 1'b1;
    batch_tasks = 8'b0101_1111;
    push(3'd0, 2'd0); push(3'd1, 2'd1); push(3'd2, 2'd2);
    push(3'd3, 2'd0); push(3'd4, 2'd1); push(3'd6, 2'd2);
    cyc();
    batch_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chk("six_dv", 32'(dispatch_valid), 32'd1);
      chk("six_trig_low", 32'(trigger), 32'd0);
      cyc();
    end
    chk("six_trig", 32'(trigger), 32'd1);
    chk("six_ready_low", 32'(batch_ready), 32'd0);
    cyc();
    chk("six_ready", 32'(batch_ready), 32'd1);
    chk("six_trig_drop", 32'(trigger), 32'd0);
    chk_counts("six", 2, 2, 2);
    chk("six_sb", 32'(sbq.size()), 32'd0);

    // Drain while idle
    done = 3'b111;
    cyc(); cyc();
    done = 3'b000;
    chk_counts("drain1", 0, 0, 0);

    // Empty batch
    batch_valid = 1'b1;
    batch_tasks = 8'h00;
    cyc();
    batch_valid = 1'b0;
    chk("empty_trig", 32'(trigger), 32'd1);
    chk("empty_dv", 32'(dispatch_valid), 32'd0);
    cyc();
    chk("empty_ready", 32'(batch_ready), 32'd1);

    // Overload and stall; counts 0/0/0, rr at 0
    batch_valid = 1'b1;
    batch_tasks = 8'hFF;
    push(3'd0, 2'd0); push(3'd1, 2'd1); push(3'd2, 2'd2);
    push(3'd3, 2'd0); push(3'd4, 2'd1); push(3'd5, 2'd2);
    push(3'd6, 2'd1); push(3'd7, 2'd0);
    cyc();
    batch_valid = 1'b0;
    for (int c = 2; c <= 6; c++) cyc();
    chk("ovl_c6_dv", 32'(dispatch_valid), 32'd1);
    cyc();
    chk("ovl_c7_dv", 32'(dispatch_valid), 32'd0);
    chk("ovl_c7_ovl", 32'(overload), 32'd1);
    chk_counts("ovl_full", 2, 2, 2);
    cyc();
    chk("ovl_stall", 32'(overload), 32'd1);
    done = 3'b010;
    cyc();
    done = 3'b000;
    chk("ovl_release_dv", 32'(dispatch_valid), 32'd1);
    chk("ovl_release_ovl", 32'(overload), 32'd0);
    cyc();
    chk("ovl_again", 32'(overload), 32'd1);
    chk("ovl_again_dv", 32'(dispatch_valid), 32'd0);
    done = 3'b001;
    cyc();
    done = 3'b000;
    chk("ovl_last_dv", 32'(dispatch_valid), 32'd1);
    cyc();
    chk("ovl_trig", 32'(trigger), 32'd1);
    cyc();
    chk("ovl_ready", 32'(batch_ready), 32'd1);
    chk_counts("ovl_end", 2, 2, 2);
    chk("ovl_sb", 32'(sbq.size()), 32'd0);

    // Reset mid-batch; counts drained, rr at 1
    done = 3'b111;
    cyc(); cyc();
    done = 3'b000;
    batch_valid = 1'b1;
    batch_tasks = 8'hFF;
    push(3'd0, 2'd1); push(3'd1, 2'd2); push(3'd2, 2'd0);
    cyc();
    batch_valid = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    chk("mid_rst_dv", 32'(dispatch_valid), 32'd0);
    chk("mid_rst_trig", 32'(trigger), 32'd0);
    chk("mid_rst_ready", 32'(batch_ready), 32'd0);
    chk_counts("mid_rst", 0, 0, 0);
    reset = 1'b0;
    cyc();
    chk("mid_rst_ready_after", 32'(batch_ready), 32'd1);
    chk("mid_rst_trig_after", 32'(trigger), 32'd0);
    chk("mid_rst_sb", 32'(sbq.size()), 32'd0);
    batch_valid = 1'b1;
    batch_tasks = 8'h01;
    push(3'd0, 2'd0);
    cyc();
    batch_valid = 1'b0;
    chk("one_dv", 32'(dispatch_valid), 32'd1);
    cyc();
    chk("one_trig", 32'(trigger), 32'd1);
    cyc();
    chk_counts("one", 1, 0, 0);

    // Done on an empty server is ignored
    done = 3'b100;
    cyc();
    done = 3'b000;
    chk_counts("done_empty", 1, 0, 0);

    // Done on server1 alongside a dispatch to server1; rr at 1
    batch_valid = 1'b1;
    batch_tasks = 8'h07;
    push(3'd0, 2'd1); push(3'd1, 2'd2); push(3'd2, 2'd0);
    cyc();
    batch_valid = 1'b0;
    cyc(); cyc();
    chk("simul_dv", 32'(dispatch_valid), 32'd1);
    chk("simul_srv", 32'(dispatch_server), 32'd0);
    done = 3'b001;
    cyc();
    done = 3'b000;
    chk("simul_trig", 32'(trigger), 32'd1);
    chk_counts("simul", 1, 1, 1);
    cyc();
    chk("simul_sb", 32'(sbq.size()), 32'd0);

    // batch_valid held with another mask while busy; rr at 1
    batch_valid = 1'b1;
    batch_tasks = 8'h03;
    push(3'd0, 2'd1); push(3'd1, 2'd2);
    cyc();
    batch_tasks = 8'hF0;
    chk("bp_ready_busy", 32'(batch_ready), 32'd0);
    cyc();
    cyc();
    chk("bp_trig", 32'(trigger), 32'd1);
    batch_valid = 1'b0;
    cyc();
    chk("bp_ready", 32'(batch_ready), 32'd1);
    chk("bp_dv", 32'(dispatch_valid), 32'd0);
    chk_counts("bp", 1, 2, 2);
    chk("bp_sb", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
